// File: rtl/phase_pkg.sv
// phase_pkg: shared constants and FSM encoding for the phase calculator
package phase_pkg;
  localparam int DEG_SCALE = 3600;
  localparam int DEG_HALF_MAX = 1799;
  localparam int DIV_W = 27;
  localparam int PER_W = 24;
  typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_e;
endpackage

// File: rtl/phase_div_serial.sv
// phase_div_serial: restoring divider, one quotient bit per clock, DIV_W iterations
module phase_div_serial #(
  parameter int DIV_W = phase_pkg::DIV_W,
  parameter int PER_W = phase_pkg::PER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PER_W-1:0] divisor,
  input  logic [DIV_W-1:0] dividend,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);
  import phase_pkg::*;
  localparam int CW = $clog2(DIV_W);
  logic [PER_W-1:0] den;
  logic [PER_W-1:0] rem;
  logic [CW-1:0] cnt;
  logic run;
  logic [PER_W:0] trial;
  logic ge;
  // quotient doubles as the dividend shift register: dividend bits leave at the top as quotient bits enter at the bottom
  assign trial = {rem, quotient[DIV_W-1]};
  assign ge = trial >= {1'b0, den};
  always_ff @(posedge clk)
    if (!rst_n) begin
      den <= '0;
      rem <= '0;
      quotient <= '0;
      cnt <= '0;
      run <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        den <= divisor;
        rem <= '0;
        quotient <= dividend;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        rem <= ge ? PER_W'(trial - {1'b0, den}) : trial[PER_W-1:0];
        quotient <= {quotient[DIV_W-2:0], ge};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DIV_W - 1)) begin
          run <= 1'b0;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/phase_calc.sv
// phase_calc: averages XOR width samples, measures reference period, and
// converts the average width to phase in 0.1-degree units
module phase_calc #(
  parameter int AVG_LOG2 = 2,
  parameter int PER_W = phase_pkg::PER_W,
  parameter int DEG_SCALE = phase_pkg::DEG_SCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_signal1,
  input  logic             done_in,
  input  logic             sta_in,
  input  logic [14:0]      width_in,
  output logic [11:0]      phase_out,
  output logic             phase_vld,
  output logic [PER_W-1:0] period_out,
  output logic             busy,
  output logic             err
);
  import phase_pkg::*;
  localparam int AW = 15 + AVG_LOG2;
  logic [2:0] sync;
  logic rise;
  logic [PER_W-1:0] count;
  logic sat;
  logic [1:0] edges;
  logic period_valid;
  state_e state;
  logic done_q;
  logic ev;
  logic sta_last;
  logic [AW-1:0] acc;
  logic [AVG_LOG2:0] cnt;
  logic full;
  logic skip;
  logic div_start;
  logic div_done;
  logic [14:0] avg;
  logic [DIV_W-1:0] num;
  logic [DIV_W-1:0] quo;
  logic [11:0] q;
  // sync[1:0] is the synchroniser, sync[2] holds the previous synchronised value
  assign rise = sync[1] & ~sync[2];
  assign sat = &count;
  assign period_valid = edges[1];
  assign ev = done_in & ~done_q;
  assign full = cnt == (AVG_LOG2 + 1)'(1 << AVG_LOG2);
  assign skip = !period_valid || period_out == '0;
  assign div_start = state == ACCUM && full && !skip;
  assign avg = 15'(acc >> AVG_LOG2);
  assign num = DIV_W'(avg) * DIV_W'(DEG_SCALE);
  assign q = quo > DIV_W'(DEG_HALF_MAX) ? 12'(DEG_HALF_MAX) : quo[11:0];
  assign busy = state == DIV || state == OUT;
  assign phase_vld = state == OUT;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync <= '0;
      count <= '0;
      edges <= '0;
      period_out <= '0;
    end else begin
      sync <= {sync[1:0], in_signal1};
      if (rise) begin
        period_out <= sat ? count : count + 1'b1;
        count <= '0;
        edges <= edges[1] ? edges : edges + 1'b1;
      end else if (!sat) begin
        count <= count + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      done_q <= 1'b0;
      acc <= '0;
      cnt <= '0;
      sta_last <= 1'b0;
      phase_out <= '0;
      err <= 1'b0;
    end else begin
      done_q <= done_in;
      if (sat) err <= 1'b1;
      case (state)
        IDLE, ACCUM:
          if (full) begin
            acc <= '0;
            cnt <= '0;
            state <= skip ? IDLE : DIV;
            if (skip) err <= 1'b1;
          end else if (ev) begin
            acc <= acc + AW'(width_in);
            cnt <= cnt + 1'b1;
            sta_last <= sta_in;
            state <= ACCUM;
          end
        DIV:
          if (div_done) begin
            phase_out <= sta_last ? q : (q == '0 ? '0 : 12'(DEG_SCALE) - q);
            state <= OUT;
          end
        default: state <= IDLE;
      endcase
    end
  phase_div_serial #(.DIV_W(DIV_W), .PER_W(PER_W)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(div_start),
    .divisor(period_out),
    .dividend(num),
    .quotient(quo),
    .done(div_done)
  );
endmodule

// File: tb/tb_phase_calc.sv
// tb_phase_calc: randomized scoreboard bench for phase_calc with a arithmetic reference model
module tb_phase_calc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_signal1 = 1'b0;
  logic done_in = 1'b0;
  logic sta_in = 1'b0;
  logic [14:0] width_in = '0;
  logic [11:0] phase_out;
  logic phase_vld;
  logic [23:0] period_out;
  logic busy;
  logic err;
  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  int per = 1000;
  bit sig_en = 1'b0;
  int last_at = 0;
  typedef struct {int phase; int at;} exp_t;
  exp_t sb[$];
  exp_t e_m;

  phase_calc #(.AVG_LOG2(2), .PER_W(24), .DEG_SCALE(3600)) dut (
    .clk(clk), .rst_n(rst_n), .in_signal1(in_signal1), .done_in(done_in),
    .sta_in(sta_in), .width_in(width_in), .phase_out(phase_out),
    .phase_vld(phase_vld), .period_out(period_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    if (sig_en) begin
      in_signal1 = 1'b1;
      repeat (per / 2) @(negedge clk);
      in_signal1 = 1'b0;
      repeat (per - per / 2) @(negedge clk);
    end else begin
      in_signal1 = 1'b0;
      @(negedge clk);
    end
  end

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // phase from the averaged width: fraction of the period scaled to a full circle
  function automatic int model(int sum, bit s, int p);
    longint qv = (longint'(sum / 4) * 3600) / p;
    if (qv > 1799) qv = 1799;
    return s ? int'(qv) : (qv == 0 ? 0 : 3600 - int'(qv));
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].at) begin
      total++;
      $display("FAIL phase_vld_missing: no strobe by cycle %0d, expected at %0d", cyc, sb[0].at);
      void'(sb.pop_front());
    end
    if (phase_vld) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL phase_vld_unexpected: strobe at cycle %0d phase %0d, none expected", cyc, phase_out);
      end else begin
        e_m = sb.pop_front();
        check("phase_value", phase_out, e_m.phase);
        check("phase_latency", cyc, e_m.at);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int w, bit s);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    done_in = 1'b1;
    width_in = 15'(w);
    sta_in = s;
    @(posedge clk);
    #1 last_at = cyc;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  task automatic window(int w0, int w1, int w2, int w3, bit s, bit expect_out);
    send(w0, 1'($urandom));
    send(w1, 1'($urandom));
    send(w2, 1'($urandom));
    send(w3, s);
    if (expect_out) sb.push_back('{model(w0 + w1 + w2 + w3, s, per), last_at + 29});
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w[4];
    idle(3);
    check("reset_phase_out", phase_out, 0);
    check("reset_phase_vld", phase_vld, 0);
    check("reset_period_out", period_out, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    window(100, 100, 100, 100, 1'b1, 1'b0);
    idle(40);
    check("err_no_period", err, 1);
    check("phase_hold_no_period", phase_out, 0);
    check("busy_after_skip", busy, 0);
    reset_pulse();
    check("err_cleared_by_reset", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sig_en = 1'b1;
    idle(2300);
    check("period_measure", period_out, 1000);
    window(250, 250, 250, 250, 1'b1, 1'b1);
    idle(40);
    window(100, 200, 300, 400, 1'b0, 1'b1);
    idle(40);
    window(1000, 1000, 1000, 1000, 1'b1, 1'b1);
    idle(40);
    window(1000, 1000, 1000, 1000, 1'b0, 1'b1);
    idle(40);
    window(250, 250, 250, 250, 1'b1, 1'b1);
    idle(3);
    check("busy_in_div", busy, 1);
    repeat (3) send(30000, 1'b0);
    idle(40);
    window(250, 250, 250, 250, 1'b1, 1'b1);
    idle(40);
    window(250, 250, 250, 250, 1'b1, 1'b0);
    idle(10);
    reset_pulse();
    check("midreset_phase_out", phase_out, 0);
    check("midreset_phase_vld", phase_vld, 0);
    check("midreset_busy", busy, 0);
    check("midreset_err", err, 0);
    check("midreset_period_out", period_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2300);
    window(300, 200, 250, 250, 1'b1, 1'b1);
    idle(40);
    for (int i = 0; i < 8; i++) begin
      foreach (w[k]) w[k] = int'($urandom_range(0, per));
      window(w[0], w[1], w[2], w[3], 1'($urandom), 1'b1);
      idle(40);
    end
    per = 640;
    idle(2100);
    check("period_measure_640", period_out, 640);
    for (int i = 0; i < 6; i++) begin
      foreach (w[k]) w[k] = int'($urandom_range(0, per));
      window(w[0], w[1], w[2], w[3], 1'($urandom), 1'b1);
      idle(40);
    end
    check("err_clean_run", err, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/phase_calc.md
Name: phase_calc

Overview:
Sits directly downstream of the XOR phase-width measurement stage and consumes its done / state / width outputs. Averages 2^AVG_LOG2 width samples and measures the in_signal1 period in clk cycles. Converts the averaged width to phase in 0.1-degree units over 0..359.9 deg, using a serial divider and the half-plane flag. The result feeds the host-interface register bank.

Parameters:
AVG_LOG2, 2, log2 of the number of width samples averaged (1..4 legal)
PER_W, 24, period counter width
DEG_SCALE, 3600, full-circle scale (0.1 deg units)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_signal1  in  1  raw reference signal (asynchronous)
done_in  in  1  width-valid strobe from upstream (clk domain, level)
sta_in  in  1  half-plane flag: 1 = 0..180 deg, 0 = 180..360 deg
width_in  in  15  XOR high-time in clk cycles
phase_out  out  12  phase, 0..3599 (0.1 deg)
phase_vld  out  1  one-cycle strobe when phase_out updates
period_out  out  24  last complete in_signal1 period in clk cycles
busy  out  1  high in DIV and OUT states
err  out  1  sticky: period invalid or counter saturated; cleared only by reset

Behaviour:
- Reset is sampled on posedge clk only. Reset values: phase_out=0, phase_vld=0, period_out=0, busy=0, err=0, FSM=IDLE, accumulator=0, sample count=0.
- in_signal1 passes through a 2-flop synchroniser. A rising edge is detected on the synchronised value.
- Period counter:
  - Increments every cycle.
  - On a rising edge: period_out<=count+1, and the counter restarts at 0.
  - If the counter reaches 2^PER_W-1, it holds there and err<=1.
  - period_valid is set after the second rising edge following reset.
- done_in rising edge (registered compare) = one sample event. Only rising edges count; level is ignored.
- FSM, IDLE/ACCUM:
  - On a sample event: acc<=acc+width_in (acc is 15+AVG_LOG2 bits), cnt<=cnt+1, sta_last<=sta_in.
  - When cnt reaches 2^AVG_LOG2: avg=acc>>AVG_LOG2 (truncate), clear acc/cnt, go to DIV.
- FSM, DIV:
  - Numerator = avg*DEG_SCALE (27 bits). Divisor = period_out.
  - Restoring divide, 1 quotient bit per cycle, 27 cycles.
  - If period_valid=0 or period_out=0: skip the divide, set err<=1, return to IDLE with no phase_vld.
  - Sample events arriving in DIV/OUT are dropped; the accumulator is not touched.
- FSM, OUT (1 cycle):
  - q = min(quotient, 1799).
  - phase_out = sta_last ? q : (q==0 ? 0 : DEG_SCALE-q).
  - phase_vld=1 for this cycle only, then IDLE.
- Latency: phase_vld rises 29 cycles after the clock edge that samples the final sample's done_in rise. That is 1 cycle capture/avg, 27 divide, 1 output.
- period_out updates independently of the FSM. The divider latches the divisor on DIV entry, so a mid-divide update does not affect the result.
- Reset asserted mid-DIV: aborts the divide, no phase_vld, and all state returns to reset values on that edge.

Decomposition:
- Package phase_pkg holds:
  - DEG_SCALE, DEG_HALF_MAX=1799, DIV_W=27, PER_W default
  - FSM enum {IDLE, ACCUM, DIV, OUT}
- One sub-module, phase_div_serial: start/divisor/dividend in; quotient/done out; fixed DIV_W iterations; synchronous reset.

Test Plan:
- Period 1000 clk, AVG_LOG2=2, four samples width 250, sta=1 -> phase_out=900, phase_vld single pulse 29 cycles after the 4th done rise.
- Same period, samples 100/200/300/400, sta=0 on the last sample -> avg 250, phase_out=2700.
- Period 1000, width 1000 (above 180-deg range), sta=1 -> quotient 3600 clamped, phase_out=1799. With sta=0 -> 1801.
- in_signal1 held low from reset, four done pulses -> no phase_vld, err=1, phase_out stays 0.
- Extra done pulses injected during DIV -> dropped; the next result uses only the four post-OUT samples.
- rst_n low for 1 cycle at DIV cycle 10 -> no phase_vld, all outputs 0, busy=0; the next full window produces the correct value.
